// File: rtl/gate_resp_checker.sv
// Response checker for the basic gates block: samples all seven outputs SETTLE_CYCLES+1 cycles
// after each stim_valid and compares them with the truth table of the captured vector.
// Optional watchdog on WAIT_STIM is enabled by defining GATE_CHK_TIMEOUT_EN.
module gate_resp_checker #(
  parameter int SETTLE_CYCLES  = 2,
  parameter int ERR_W          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stim_valid,
  input  logic             a,
  input  logic             b,
  input  logic             and_out,
  input  logic             or_out,
  input  logic             not_a,
  input  logic             nand_out,
  input  logic             nor_out,
  input  logic             xor_out,
  input  logic             xnor_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic [6:0]       first_fail_mask,
  output logic [3:0]       cov_mask,
  output logic             timeout
);

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       ffv_q, ffv_d;
  logic [6:0]       ffm_q, ffm_d;
  logic [3:0]       cov_q, cov_d;
  logic             pass_q, pass_d;
  logic             to_q, to_d;
  logic [6:0]       exp_out, got_out, mis_mask;
  logic [3:0]       cov_new;

`ifdef GATE_CHK_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q, wd_d;
`endif

  // Expected outputs come from the captured vector so a/b may change while settling.
  always_comb begin
    exp_out[0] = vec_q[1] & vec_q[0];
    exp_out[1] = vec_q[1] | vec_q[0];
    exp_out[2] = ~vec_q[1];
    exp_out[3] = ~(vec_q[1] & vec_q[0]);
    exp_out[4] = ~(vec_q[1] | vec_q[0]);
    exp_out[5] = vec_q[1] ^ vec_q[0];
    exp_out[6] = ~(vec_q[1] ^ vec_q[0]);
  end

  assign got_out  = {xnor_out, xor_out, nor_out, nand_out, not_a, or_out, and_out};
  assign mis_mask = got_out ^ exp_out;
  assign cov_new  = cov_q | (4'b0001 << vec_q);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffm_d   = ffm_q;
    cov_d   = cov_q;
    pass_d  = pass_q;
    to_d    = to_q;
`ifdef GATE_CHK_TIMEOUT_EN
    wd_d    = '0;
`endif
    if (start) begin
      state_d = S_WAIT;
      err_d   = '0;
      ffv_d   = '0;
      ffm_d   = '0;
      cov_d   = '0;
      pass_d  = 1'b0;
      to_d    = 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (stim_valid) begin
            vec_d = {a, b};
            cnt_d = CW'(SETTLE_CYCLES);
            state_d = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
          end
`ifdef GATE_CHK_TIMEOUT_EN
          else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
            to_d    = 1'b1;
            pass_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            wd_d = wd_q + WDW'(1);
          end
`endif
        end
        S_SETTLE: begin
          // A fresh vector while settling supersedes the pending sample.
          if (stim_valid) begin
            vec_d = {a, b};
            cnt_d = CW'(SETTLE_CYCLES);
          end else if (cnt_q <= CW'(1)) begin
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_SAMPLE: begin
          cov_d = cov_new;
          if (mis_mask != 7'd0) begin
            if (err_q == '0) begin
              ffv_d = vec_q;
              ffm_d = mis_mask;
            end
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
          end
          if (cov_new == 4'hF) begin
            state_d = S_DONE;
            pass_d  = (err_d == '0) && !to_q;
          end else begin
            state_d = S_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffv_q   <= '0;
      ffm_q   <= '0;
      cov_q   <= '0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffm_q   <= ffm_d;
      cov_q   <= cov_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
    end
  end

`ifdef GATE_CHK_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy            = (state_q == S_WAIT) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done            = (state_q == S_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_mask = ffm_q;
  assign cov_mask        = cov_q;

endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Self-checking response side for the basic logic gates block.
- Captures each applied (a,b) stimulus, waits a settle time, then samples all seven gate outputs and compares them against the truth table.
- Accumulates mismatches and per-vector coverage, and reports pass/fail once all four input combinations have been checked.
- Sits beside the gates block in a synthesizable self-test harness; the stimulus source pulses stim_valid each time it applies a new vector.

Parameters:
SETTLE_CYCLES, 2, clock cycles between stimulus capture and output sampling (0 allowed)
ERR_W, 8, width of the saturating error counter
TIMEOUT_CYCLES, 64, watchdog limit; used only when GATE_CHK_TIMEOUT_EN is defined

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; clears results and begins a check run
stim_valid  in  1  one-cycle pulse; a and b hold a newly applied vector
a  in  1  stimulus input a
b  in  1  stimulus input b
and_out, or_out, not_a, nand_out, nor_out, xor_out, xnor_out  in  1 each  gate outputs under check
busy  out  1  high from the cycle after start until done
done  out  1  high when the run has finished; held until the next start
pass  out  1  valid when done; 1 iff err_count==0 and no timeout
err_count  out  ERR_W  number of sampled vectors with any mismatch; saturates at all-ones
first_fail_vec  out  2  {a,b} of the first failing sample
first_fail_mask  out  7  mismatch mask of the first failing sample
cov_mask  out  4  bit i set once vector {a,b}==i has been sampled
timeout  out  1  watchdog fired; tied 0 when the feature is compiled out

Behaviour:
- Reset (asynchronous, rst_n=0): FSM goes to IDLE; all outputs and internal registers are 0.
- States and transitions:
  - IDLE: start -> WAIT_STIM.
  - WAIT_STIM: stim_valid -> capture {a,b} into vec; go to SETTLE (load the counter with SETTLE_CYCLES), or straight to SAMPLE if SETTLE_CYCLES==0.
  - SETTLE: counter decrements each cycle; moves to SAMPLE on the cycle the counter reaches 0.
  - SAMPLE: one cycle; compare, then go to DONE if the updated cov_mask==4'hF, otherwise back to WAIT_STIM.
  - DONE: hold all results.
- Sampling latency: outputs are sampled exactly SETTLE_CYCLES+1 cycles after the stim_valid cycle.
- start behaviour: the cycle after start, err_count, cov_mask, first_fail_* and timeout are cleared, pass=0 and done=0.
- Expected values are computed from the captured vec, not from live a/b:
  - and = a&b; or = a|b; not_a = ~a; nand = ~(a&b); nor = ~(a|b); xor = a^b; xnor = ~(a^b).
- Mismatch mask bit order: bit0 and, bit1 or, bit2 not_a, bit3 nand, bit4 nor, bit5 xor, bit6 xnor.
- On a mask != 0:
  - err_count increments, saturating at 2^ERR_W-1.
  - If this is the first failure of the run, latch first_fail_vec and first_fail_mask.
- cov_mask[vec] is set in SAMPLE regardless of the result. A repeated vector is re-checked and counted, but coverage is unchanged.
- busy=1 in WAIT_STIM, SETTLE and SAMPLE.
- done and pass update in the same cycle the FSM enters DONE.
- Boundary and simultaneous-event cases:
  - stim_valid during SETTLE: the new vector replaces vec, the settle counter reloads, and the pending sample is dropped.
  - stim_valid during SAMPLE, IDLE or DONE: ignored.
  - start in any state (including mid-run): restarts the run. start takes priority over stim_valid in the same cycle.
  - rst_n asserted mid-run: immediate return to IDLE with all outputs 0.

Optional Feature:
- GATE_CHK_TIMEOUT_EN defined:
  - A watchdog counts consecutive cycles spent in WAIT_STIM and clears on stim_valid.
  - Reaching TIMEOUT_CYCLES sets timeout=1 and moves the FSM to DONE with pass=0 and cov_mask left as-is.
- Not defined: no watchdog logic; the block waits indefinitely in WAIT_STIM; timeout is constant 0.

Test Plan:
- Correct gates, SETTLE_CYCLES=2, vectors 00,01,10,11 each pulsed -> done=1, pass=1, err_count=0, cov_mask=4'hF; each sample taken 3 cycles after its stim_valid.
- Force xor_out stuck at 0, vectors 00,01,10,11 -> err_count=2, first_fail_vec=2'b01, first_fail_mask=7'b0100000, pass=0.
- Vectors 00,00,01,11 only -> cov_mask=4'b1011, busy=1, done=0; then 10 -> done=1.
- stim_valid with 01 then stim_valid with 10 one cycle later (inside SETTLE) -> only 10 is sampled; cov_mask=4'b0100.
- rst_n=0 while in SETTLE with err_count=1 -> all outputs 0 immediately; after release, start is required to resume.
- With GATE_CHK_TIMEOUT_EN, TIMEOUT_CYCLES=64, start and then no stim_valid -> after 64 cycles timeout=1, done=1, pass=0.
